replay_demux: RTL and testbench

Receive-side counterpart of the spike replay buffer. It takes the time-multiplexed spike stream produced by a shared (multiplexed) column and expands it back into `NUM_INPUTS` independent, real-time spike streams. During each gamma window it captures `NUM_INPUTS` compressed sub-windows into a ping-pong register bank. During the following window it replays each sub-window on its own output lane, stretched by `NUM_INPUTS`. It sits between the multiplexed column output and the per-layer consumers (next-layer inputs, STDP/readout).

---
 rtl/replay_demux.sv | 153 +++++++++++++++
 tb/tb_replay_demux.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/replay_demux.sv
// replay_demux: captures NUM_INPUTS compressed sub-windows of a time-multiplexed
// spike stream per gamma window into a ping-pong bank, then replays each
// sub-window on its own lane during the following window, stretched by NUM_INPUTS.
module replay_demux #(
    parameter int unsigned P          = 64,
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned GAMMA_LEN  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    gamma_start,
    input  logic [P-1:0]            data_in,
    output logic [NUM_INPUTS*P-1:0] data_out,
    output logic                    out_valid,
    output logic                    frame_err
);

    localparam int unsigned SUB_LEN = GAMMA_LEN / NUM_INPUTS;
    // Counter needs one extra code: GAMMA_LEN marks "window complete, awaiting gamma_start".
    localparam int unsigned CW      = $clog2(GAMMA_LEN + 1);
    localparam int unsigned IW      = (GAMMA_LEN > 1) ? $clog2(GAMMA_LEN) : 1;
    localparam logic [CW-1:0] CNT_END = CW'(GAMMA_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cyc_cnt, cyc_cnt_nxt;
    logic                 bank_sel, bank_sel_nxt;
    logic                 has_data, has_data_nxt;
    logic                 playing, playing_nxt;
    logic                 swap;
    logic                 wr_en;
    logic                 err;
    logic                 play;
    logic                 rd_bank;
    logic [CW-1:0]        rd_ofs;
    logic [CW-1:0]        rd_slot;
    logic [NUM_INPUTS*P-1:0] data_nxt;

    // Entry index within a bank is sub*SUB_LEN+pos, which equals the window offset.
    logic [P-1:0]         mem [2][GAMMA_LEN];

    // State and control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cyc_cnt  <= '0;
            bank_sel <= 1'b0;
            has_data <= 1'b0;
            playing  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cyc_cnt  <= cyc_cnt_nxt;
            bank_sel <= bank_sel_nxt;
            has_data <= has_data_nxt;
            playing  <= playing_nxt;
        end
    end

    // Next-state: gamma_start always swaps; cyc_cnt holds the offset of the current cycle
    always_comb begin
        state_nxt    = state;
        cyc_cnt_nxt  = cyc_cnt;
        bank_sel_nxt = bank_sel;
        has_data_nxt = has_data;
        playing_nxt  = playing;
        swap         = 1'b0;
        wr_en        = 1'b0;
        err          = 1'b0;
        if (gamma_start) begin
            swap         = 1'b1;
            state_nxt    = ST_RUN;
            cyc_cnt_nxt  = CW'(1);
            bank_sel_nxt = ~bank_sel;
            // has_data means the bank about to become rbank holds a captured window
            has_data_nxt = 1'b1;
            playing_nxt  = has_data;
            err          = (state == ST_RUN) && (cyc_cnt != CNT_END);
        end else begin
            case (state)
                ST_RUN: begin
                    if (cyc_cnt == CNT_END) begin
                        state_nxt   = ST_WAIT;
                        playing_nxt = 1'b0;
                        err         = 1'b1;
                    end else begin
                        wr_en       = 1'b1;
                        cyc_cnt_nxt = cyc_cnt + CW'(1);
                    end
                end
                ST_IDLE: ;
                ST_WAIT: ;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Capture bank: clear-and-seed on swap, sequential fill while running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < GAMMA_LEN; e++) begin
                    mem[b][e] <= '0;
                end
            end
        end else if (swap) begin
            for (int e = 0; e < GAMMA_LEN; e++) begin
                mem[~bank_sel][e] <= '0;
            end
            mem[~bank_sel][0] <= data_in;
        end else if (wr_en) begin
            mem[bank_sel][cyc_cnt[IW-1:0]] <= data_in;
        end
    end

    // Playback select: on the swap cycle read offset 0 of the bank that is becoming rbank
    always_comb begin
        if (gamma_start) begin
            play    = has_data;
            rd_bank = bank_sel;
            rd_ofs  = '0;
        end else begin
            play    = playing && (state == ST_RUN) && (cyc_cnt != CNT_END);
            rd_bank = ~bank_sel;
            rd_ofs  = cyc_cnt;
        end
        rd_slot  = rd_ofs / CW'(NUM_INPUTS);
        data_nxt = '0;
        if (play && ((rd_ofs % CW'(NUM_INPUTS)) == '0)) begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                data_nxt[k*P +: P] = mem[rd_bank][IW'(CW'(k * SUB_LEN) + rd_slot)];
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            data_out  <= data_nxt;
            out_valid <= play;
            frame_err <= err;
        end
    end

endmodule

// File: tb/tb_replay_demux.sv
// Directed bench for replay_demux (P=64, NUM_INPUTS=2, GAMMA_LEN=16).
// Cycle n is the interval after the n-th rising edge since reset assertion;
// outputs are sampled 1 time unit after the edge, inputs driven right after.
module tb_replay_demux;

    localparam int unsigned P  = 64;
    localparam int unsigned NI = 2;
    localparam int unsigned GL = 16;

    logic              clk;
    logic              rst;
    logic              gamma_start;
    logic [P-1:0]      data_in;
    logic [NI*P-1:0]   data_out;
    logic              out_valid;
    logic              frame_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    replay_demux #(
        .P          (P),
        .NUM_INPUTS (NI),
        .GAMMA_LEN  (GL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gamma_start (gamma_start),
        .data_in     (data_in),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        gamma_start = 1'b0;
        data_in     = '0;
        cyc         = 0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    // Scenario 1: first window after reset produces no output at all
    task automatic test_reset();
        logic [NI*P+1:0] got;
        do_reset();
        while (cyc <= 26) begin
            got = {data_out, out_valid, frame_err};
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_first_window cyc=%0d got=%h expected=0", cyc, got);
            end
            data_in     = {$urandom, $urandom};
            gamma_start = (cyc == 10);
            tick();
        end
        gamma_start = 1'b0;
    endtask

    // Scenario 2: single spikes land on the right lane at the stretched offset
    task automatic test_basic_expansion();
        logic [NI*P-1:0] exp_data;
        logic            exp_valid;
        logic            exp_err;
        do_reset();
        while (cyc <= 44) begin
            exp_data = '0;
            if (cyc == 33) exp_data[5] = 1'b1;
            if (cyc == 31) exp_data[71] = 1'b1;
            exp_valid = (cyc >= 27 && cyc <= 42);
            exp_err   = (cyc == 43);
            checks++;
            if ({data_out, out_valid, frame_err} !== {exp_data, exp_valid, exp_err}) begin
                errors++;
                $display("FAIL basic_expansion cyc=%0d got data=%h v=%b e=%b expected data=%h v=%b e=%b",
                         cyc, data_out, out_valid, frame_err, exp_data, exp_valid, exp_err);
            end
            data_in = '0;
            if (cyc == 13) data_in[5] = 1'b1;
            if (cyc == 20) data_in[7] = 1'b1;
            gamma_start = (cyc == 10 || cyc == 26);
            tick();
        end
        gamma_start = 1'b0;
    endtask

    // Scenario 3: all-ones window replays as ones on even offsets only
    task automatic test_full_rate();
        logic [NI*P-1:0] exp_data;
        logic            exp_valid;
        logic            exp_err;
        do_reset();
        while (cyc <= 44) begin
            exp_valid = (cyc >= 27 && cyc <= 42);
            exp_data  = (exp_valid && ((cyc - 27) % 2 == 0)) ? '1 : '0;
            exp_err   = (cyc == 43);
            checks++;
            if ({data_out, out_valid, frame_err} !== {exp_data, exp_valid, exp_err}) begin
                errors++;
                $display("FAIL full_rate cyc=%0d got data=%h v=%b e=%b expected data=%h v=%b e=%b",
                         cyc, data_out, out_valid, frame_err, exp_data, exp_valid, exp_err);
            end
            data_in     = (cyc >= 10 && cyc <= 25) ? '1 : '0;
            gamma_start = (cyc == 10 || cyc == 26);
            tick();
        end
        gamma_start = 1'b0;
    endtask

    // Scenario 4: early gamma_start cuts playback, flags, replays the short window
    task automatic test_early_start();
        logic [NI*P-1:0] exp_data;
        logic            exp_valid;
        logic            exp_err;
        do_reset();
        while (cyc <= 53) begin
            exp_data = '0;
            if (cyc == 27) exp_data[0]  = 1'b1;
            if (cyc == 36) exp_data[67] = 1'b1;
            if (cyc == 44) exp_data[9]  = 1'b1;
            exp_valid = (cyc >= 27 && cyc <= 51);
            exp_err   = (cyc == 36 || cyc == 52);
            checks++;
            if ({data_out, out_valid, frame_err} !== {exp_data, exp_valid, exp_err}) begin
                errors++;
                $display("FAIL early_start cyc=%0d got data=%h v=%b e=%b expected data=%h v=%b e=%b",
                         cyc, data_out, out_valid, frame_err, exp_data, exp_valid, exp_err);
            end
            data_in = '0;
            if (cyc == 10) data_in[0] = 1'b1;
            if (cyc == 25) data_in[2] = 1'b1;
            if (cyc == 30) data_in[9] = 1'b1;
            if (cyc == 34) data_in[3] = 1'b1;
            gamma_start = (cyc == 10 || cyc == 26 || cyc == 35);
            tick();
        end
        gamma_start = 1'b0;
    endtask

    // Scenario 5: overrun enters WAIT, input ignored, recovery replays the old window
    task automatic test_overrun();
        logic [NI*P-1:0] exp_data;
        logic            exp_valid;
        logic            exp_err;
        do_reset();
        while (cyc <= 58) begin
            exp_data = '0;
            if (cyc == 45) exp_data[1]  = 1'b1;
            if (cyc == 55) exp_data[72] = 1'b1;
            exp_valid = (cyc >= 41 && cyc <= 56);
            exp_err   = (cyc == 27 || cyc == 57);
            checks++;
            if ({data_out, out_valid, frame_err} !== {exp_data, exp_valid, exp_err}) begin
                errors++;
                $display("FAIL overrun cyc=%0d got data=%h v=%b e=%b expected data=%h v=%b e=%b",
                         cyc, data_out, out_valid, frame_err, exp_data, exp_valid, exp_err);
            end
            data_in = '0;
            if (cyc == 12) data_in[1]  = 1'b1;
            if (cyc == 25) data_in[8]  = 1'b1;
            if (cyc == 26) data_in[4]  = 1'b1;
            if (cyc == 30) data_in[4]  = 1'b1;
            if (cyc == 39) data_in[6]  = 1'b1;
            if (cyc == 40) data_in[10] = 1'b1;
            gamma_start = (cyc == 10 || cyc == 40);
            tick();
        end
        gamma_start = 1'b0;
    endtask

    // Back-to-back gamma_start: second pulse is early and replays a one-entry window
    task automatic test_back_to_back();
        logic [NI*P-1:0] exp_data;
        logic            exp_valid;
        logic            exp_err;
        do_reset();
        while (cyc <= 45) begin
            exp_data = '0;
            if (cyc == 28) exp_data[0] = 1'b1;
            exp_valid = (cyc >= 27 && cyc <= 43);
            exp_err   = (cyc == 28 || cyc == 44);
            checks++;
            if ({data_out, out_valid, frame_err} !== {exp_data, exp_valid, exp_err}) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got data=%h v=%b e=%b expected data=%h v=%b e=%b",
                         cyc, data_out, out_valid, frame_err, exp_data, exp_valid, exp_err);
            end
            data_in = '0;
            if (cyc == 11) data_in[12] = 1'b1;
            if (cyc == 26) data_in[0]  = 1'b1;
            if (cyc == 27) data_in[1]  = 1'b1;
            gamma_start = (cyc == 10 || cyc == 26 || cyc == 27);
            tick();
        end
        gamma_start = 1'b0;
    endtask

    // Scenario 6: reset mid-playback clears outputs at once; next window gives no playback
    task automatic test_mid_reset();
        logic [NI*P-1:0] exp_data;
        logic            exp_valid;
        logic            exp_err;
        logic [NI*P+1:0] got;
        do_reset();
        while (cyc <= 67) begin
            exp_data = '0;
            if (cyc == 67) exp_data[11] = 1'b1;
            exp_valid = (cyc >= 27 && cyc <= 30) || (cyc >= 57);
            exp_err   = 1'b0;
            checks++;
            if ({data_out, out_valid, frame_err} !== {exp_data, exp_valid, exp_err}) begin
                errors++;
                $display("FAIL mid_reset cyc=%0d got data=%h v=%b e=%b expected data=%h v=%b e=%b",
                         cyc, data_out, out_valid, frame_err, exp_data, exp_valid, exp_err);
            end
            if (cyc == 30) begin
                rst = 1'b0;
                #1;
                got = {data_out, out_valid, frame_err};
                checks++;
                if (got !== '0) begin
                    errors++;
                    $display("FAIL mid_reset_async cyc=%0d got=%h expected=0", cyc, got);
                end
            end
            if (cyc == 33) rst = 1'b1;
            data_in = '0;
            if (cyc == 13) data_in[5]  = 1'b1;
            if (cyc == 20) data_in[7]  = 1'b1;
            if (cyc == 45) data_in[11] = 1'b1;
            gamma_start = (cyc == 10 || cyc == 26 || cyc == 40 || cyc == 56);
            tick();
        end
        gamma_start = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        gamma_start = 1'b0;
        data_in     = '0;
        test_reset();
        test_basic_expansion();
        test_full_rate();
        test_early_start();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
